// File: rtl/rangefinder_sample_capture.sv
// Rangefinder acquisition front end: waits for a laser-fire trigger, skips a blanking
// window, then streams one decimated echo record into port 2 of the sample RAM.
module rangefinder_sample_capture #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned DECIM   = 1,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              arm_i,
   input  logic              abort_i,
   input  logic              trig_i,
   input  logic [15:0]       holdoff_i,
   input  logic              adc_valid_i,
   input  logic [DATA_W-1:0] adc_data_i,
   output logic [ADDR_W-1:0] ram_address2_o,
   output logic              ram_chipselect2_o,
   output logic              ram_write2_o,
   output logic [DATA_W-1:0] ram_writedata2_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic              irq_o
);

   localparam int unsigned DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [DCW-1:0]    DecimLast = DCW'(DECIM - 1);
   localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(DEPTH - 1);
   localparam logic [15:0]       TcntLast  = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWaitTrig,
      StHoldoff,
      StCapture,
      StDone
   } state_e;

   state_e            state_q;
   logic              trig_q;
   logic [15:0]       tcnt_q;
   logic [15:0]       hcnt_q;
   logic [DCW-1:0]    dcnt_q;
   logic [ADDR_W-1:0] index_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wr_q;
   logic              busy_q;
   logic              done_q;
   logic              timeout_q;
   logic              irq_q;
   logic              rise;

   assign rise = trig_i & ~trig_q;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= StIdle;
         trig_q    <= 1'b0;
         tcnt_q    <= '0;
         hcnt_q    <= '0;
         dcnt_q    <= '0;
         index_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         trig_q <= trig_i;
         irq_q  <= 1'b0;
         wr_q   <= 1'b0;
         if (abort_i) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
         end else begin
            case (state_q)
               StIdle, StDone: begin
                  if (arm_i) begin
                     state_q   <= StWaitTrig;
                     busy_q    <= 1'b1;
                     done_q    <= 1'b0;
                     timeout_q <= 1'b0;
                     index_q   <= '0;
                     tcnt_q    <= '0;
                  end
               end
               StWaitTrig: begin
                  if (rise) begin
                     dcnt_q <= '0;
                     if (holdoff_i != 16'd0) begin
                        state_q <= StHoldoff;
                        hcnt_q  <= holdoff_i;
                     end else begin
                        state_q <= StCapture;
                     end
                  end else if ((TIMEOUT != 0) && (tcnt_q == TcntLast)) begin
                     state_q   <= StIdle;
                     busy_q    <= 1'b0;
                     timeout_q <= 1'b1;
                     irq_q     <= 1'b1;
                  end else begin
                     tcnt_q <= tcnt_q + 16'd1;
                  end
               end
               StHoldoff: begin
                  // The beat that empties the blanking count is itself discarded.
                  if (adc_valid_i) begin
                     if (hcnt_q == 16'd1) begin
                        state_q <= StCapture;
                     end else begin
                        hcnt_q <= hcnt_q - 16'd1;
                     end
                  end
               end
               StCapture: begin
                  if (adc_valid_i) begin
                     dcnt_q <= (dcnt_q == DecimLast) ? '0 : dcnt_q + DCW'(1);
                     if (dcnt_q == '0) begin
                        wr_q    <= 1'b1;
                        addr_q  <= index_q;
                        wdata_q <= adc_data_i;
                        // Final write lands in the first DONE cycle; index stays at the top.
                        if (index_q == LastIdx) begin
                           state_q <= StDone;
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                           irq_q   <= 1'b1;
                        end else begin
                           index_q <= index_q + ADDR_W'(1);
                        end
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign ram_address2_o    = addr_q;
   assign ram_chipselect2_o = wr_q;
   assign ram_write2_o      = wr_q;
   assign ram_writedata2_o  = wdata_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign timeout_o         = timeout_q;
   assign irq_o             = irq_q;

endmodule
